// File: rtl/usb_parallel_responder.sv
// Device-side responder for the 8-bit async parallel host port: pointer/data register access,
// W1C interrupt status with enable mask, and a local write port into the same register file.
module usb_parallel_responder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned MIN_GAP_CYCLES = 4,
    parameter logic [7:0]  IRQ_STAT_ADDR  = 8'h0D,
    parameter logic [7:0]  IRQ_EN_ADDR    = 8'h0E
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       intrq,
    input  logic [7:0] ev_set,
    input  logic       loc_we,
    input  logic [7:0] loc_addr,
    input  logic [7:0] loc_wdata,
    output logic       loc_drop,
    output logic       gap_err,
    output logic       proto_err
);

    localparam int unsigned CNT_W = $clog2(MIN_GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(MIN_GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD, WR, RELEASE, RECOVER} state_t;

    logic [SYNC_STAGES-1:0] cs_sync, rd_sync, wr_sync, a0_sync;
    logic [7:0]             din_sync [SYNC_STAGES];

    state_t            state, state_d;
    logic [7:0]        ptr, ptr_d, irq_stat, irq_stat_d, irq_en, irq_en_d;
    logic [7:0]        data_out_d, wdata, wdata_d, rd_value;
    logic              data_oe_d, intrq_d, loc_drop_d, gap_err_d, proto_err_d;
    logic              acc_a0, acc_a0_d, acc_wr, acc_wr_d, armed, armed_d;
    logic [CNT_W-1:0]  gap_cnt, gap_cnt_d;
    logic              decode, bus_mem_we, loc_mem_we;
    logic              cs_act, rd_act, wr_act, a0_s;
    logic [7:0]        din_s;
    logic [7:0]        mem [256];

    // cs sync resets to "asserted" so a strobe held across reset release is not decoded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync <= '0;
            rd_sync <= '1;
            wr_sync <= '1;
            a0_sync <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) din_sync[i] <= '0;
        end else begin
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            rd_sync     <= {rd_sync[SYNC_STAGES-2:0], rd_n};
            wr_sync     <= {wr_sync[SYNC_STAGES-2:0], wr_n};
            a0_sync     <= {a0_sync[SYNC_STAGES-2:0], a0};
            din_sync[0] <= data_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) din_sync[i] <= din_sync[i-1];
        end
    end

    assign cs_act = !cs_sync[SYNC_STAGES-1];
    assign rd_act = !rd_sync[SYNC_STAGES-1];
    assign wr_act = !wr_sync[SYNC_STAGES-1];
    assign a0_s   = a0_sync[SYNC_STAGES-1];
    assign din_s  = din_sync[SYNC_STAGES-1];

    always_comb begin
        rd_value = ptr;
        if (acc_a0) begin
            if (ptr == IRQ_STAT_ADDR)    rd_value = irq_stat;
            else if (ptr == IRQ_EN_ADDR) rd_value = irq_en;
            else                         rd_value = mem[ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            irq_stat  <= '0;
            irq_en    <= '0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            intrq     <= 1'b0;
            loc_drop  <= 1'b0;
            gap_err   <= 1'b0;
            proto_err <= 1'b0;
            acc_a0    <= 1'b0;
            acc_wr    <= 1'b0;
            wdata     <= '0;
            gap_cnt   <= '0;
            armed     <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            irq_stat  <= irq_stat_d;
            irq_en    <= irq_en_d;
            data_out  <= data_out_d;
            data_oe   <= data_oe_d;
            intrq     <= intrq_d;
            loc_drop  <= loc_drop_d;
            gap_err   <= gap_err_d;
            proto_err <= proto_err_d;
            acc_a0    <= acc_a0_d;
            acc_wr    <= acc_wr_d;
            wdata     <= wdata_d;
            gap_cnt   <= gap_cnt_d;
            armed     <= armed_d;
        end
    end

    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        irq_stat_d  = irq_stat;
        irq_en_d    = irq_en;
        data_out_d  = data_out;
        data_oe_d   = 1'b0;
        intrq_d     = |(irq_stat & irq_en);
        loc_drop_d  = 1'b0;
        gap_err_d   = 1'b0;
        proto_err_d = 1'b0;
        acc_a0_d    = acc_a0;
        acc_wr_d    = acc_wr;
        wdata_d     = wdata;
        armed_d     = armed | !cs_act;
        decode      = 1'b0;
        bus_mem_we  = 1'b0;
        loc_mem_we  = 1'b0;
        // counts consecutive synchronised cs-high cycles, saturating
        if (!cs_act) gap_cnt_d = (gap_cnt == GAP_LAST) ? gap_cnt : gap_cnt + CNT_W'(1);
        else         gap_cnt_d = '0;

        case (state)
            IDLE: begin
                gap_cnt_d = '0;
                decode    = armed;
            end
            RD: begin
                data_oe_d  = 1'b1;
                data_out_d = rd_value;
                if (!cs_act || !rd_act) state_d = RELEASE;
            end
            WR: begin
                if (!cs_act || !wr_act) begin
                    wdata_d = din_s;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (acc_wr && !acc_a0) begin
                    ptr_d = wdata;
                end else if (acc_a0) begin
                    if (acc_wr) begin
                        if (ptr == IRQ_STAT_ADDR)    irq_stat_d = irq_stat & ~wdata;
                        else if (ptr == IRQ_EN_ADDR) irq_en_d   = wdata;
                        else                         bus_mem_we = 1'b1;
                    end
                    ptr_d = ptr + 8'd1;
                end
                state_d = RECOVER;
            end
            RECOVER: begin
                if (cs_act) begin
                    gap_err_d = 1'b1;
                    decode    = 1'b1;
                    state_d   = IDLE;
                end else if (gap_cnt == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (decode && cs_act) begin
            if (rd_act && wr_act) begin
                proto_err_d = 1'b1;
                state_d     = IDLE;
            end else if (rd_act) begin
                state_d  = RD;
                acc_a0_d = a0_s;
                acc_wr_d = 1'b0;
            end else if (wr_act) begin
                state_d  = WR;
                acc_a0_d = a0_s;
                acc_wr_d = 1'b1;
            end
        end

        // event set applied last so it wins over a same-cycle W1C
        irq_stat_d = irq_stat_d | ev_set;

        if (loc_we && loc_addr != IRQ_STAT_ADDR && loc_addr != IRQ_EN_ADDR) begin
            if (bus_mem_we && loc_addr == ptr) loc_drop_d = 1'b1;
            else                               loc_mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (loc_mem_we) mem[loc_addr] <= loc_wdata;
        if (bus_mem_we) mem[ptr]      <= wdata;
    end

endmodule

// File: tb/tb_usb_parallel_responder.sv
// Directed bench for usb_parallel_responder: host bus tasks, read-data scoreboard, pulse monitors.
module tb_usb_parallel_responder;

    localparam int unsigned SYNC_STAGES = 2;

    logic       clk, rst, cs_n, rd_n, wr_n, a0;
    logic [7:0] data_in, data_out, ev_set, loc_addr, loc_wdata;
    logic       data_oe, intrq, loc_we, loc_drop, gap_err, proto_err;

    int errors = 0;
    int checks = 0;
    int gap_seen = 0, proto_seen = 0, drop_seen = 0, oe_seen = 0;
    logic [7:0] exp_q [$];

    usb_parallel_responder #(
        .SYNC_STAGES(SYNC_STAGES), .MIN_GAP_CYCLES(4),
        .IRQ_STAT_ADDR(8'h0D), .IRQ_EN_ADDR(8'h0E)
    ) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
        .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .intrq(intrq),
        .ev_set(ev_set), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .loc_drop(loc_drop), .gap_err(gap_err), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (gap_err === 1'b1)   gap_seen++;
        if (proto_err === 1'b1) proto_seen++;
        if (loc_drop === 1'b1)  drop_seen++;
        if (data_oe === 1'b1)   oe_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // event/local-write injection lands in the commit cycle: SYNC_STAGES+1 clocks after release
    task automatic bus_write(input logic a, input logic [7:0] d, input int gap = 10,
                             input logic inj = 1'b0, input logic [7:0] la = 8'h00,
                             input logic [7:0] ld = 8'h00, input logic [7:0] ev = 8'h00);
        cs_n = 1'b0; a0 = a; data_in = d;
        @(negedge clk);
        wr_n = 1'b0;
        repeat (6) @(negedge clk);
        wr_n = 1'b1; cs_n = 1'b1;
        for (int i = 1; i <= gap; i++) begin
            @(negedge clk);
            if (i == int'(SYNC_STAGES) + 1) begin
                loc_we = inj; loc_addr = la; loc_wdata = ld; ev_set = ev;
            end else begin
                loc_we = 1'b0; ev_set = 8'h00;
            end
        end
        loc_we = 1'b0; ev_set = 8'h00;
    endtask

    task automatic bus_read(input logic a, input logic [7:0] exp, input string tag);
        int waited;
        logic [7:0] want;
        exp_q.push_back(exp);
        cs_n = 1'b0; rd_n = 1'b0; a0 = a;
        waited = 0;
        while (data_oe !== 1'b1 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        want = exp_q.pop_front();
        if (data_oe !== 1'b1) check({tag, "_timeout"}, 8'(data_oe), 8'h01);
        else                  check(tag, data_out, want);
        repeat (3) @(negedge clk);
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int snap, lat;
        rst = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; data_in = 8'h00;
        ev_set = 8'h00; loc_we = 1'b0; loc_addr = 8'h00; loc_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_oe", 8'(data_oe), 8'h00);
        check("rst_intrq", 8'(intrq), 8'h00);
        check("rst_pulses", {5'b0, loc_drop, gap_err, proto_err}, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // T1 pointer + data write, readback, read latency
        bus_write(1'b0, 8'h20);
        bus_write(1'b1, 8'hA5);
        bus_read(1'b0, 8'h21, "t1_ptr_after_wr");
        bus_write(1'b0, 8'h20);
        cs_n = 1'b0; rd_n = 1'b0; a0 = 1'b1; lat = 0;
        while (data_oe !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
        check("t1_rd_latency_ok", 8'(lat <= int'(SYNC_STAGES) + 2), 8'h01);
        check("t1_mem_rd", data_out, 8'hA5);
        repeat (3) @(negedge clk);
        rd_n = 1'b1; cs_n = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(1'b0, 8'h21, "t1_ptr_after_rd");

        // T2 pointer wrap
        bus_write(1'b0, 8'hFF);
        bus_write(1'b1, 8'h11);
        bus_write(1'b1, 8'h22);
        bus_read(1'b0, 8'h01, "t2_ptr_wrap");
        bus_write(1'b0, 8'hFF);
        bus_read(1'b1, 8'h11, "t2_mem_ff");
        bus_read(1'b1, 8'h22, "t2_mem_00");

        // T3 interrupt enable, set, W1C, set-wins
        bus_write(1'b0, 8'h0E);
        bus_write(1'b1, 8'h01);
        check("t3_intrq_quiet", 8'(intrq), 8'h00);
        ev_set = 8'h01; @(negedge clk); ev_set = 8'h00;
        repeat (3) @(negedge clk);
        check("t3_intrq_set", 8'(intrq), 8'h01);
        bus_write(1'b0, 8'h0D);
        bus_read(1'b1, 8'h01, "t3_stat_rd");
        bus_read(1'b1, 8'h01, "t3_en_rd");
        bus_write(1'b0, 8'h0D);
        bus_write(1'b1, 8'h01);
        check("t3_intrq_w1c", 8'(intrq), 8'h00);
        ev_set = 8'h01; @(negedge clk); ev_set = 8'h00;
        bus_write(1'b0, 8'h0D);
        bus_write(1'b1, 8'h01, 10, 1'b0, 8'h00, 8'h00, 8'h01);
        check("t3_set_wins", 8'(intrq), 8'h01);
        bus_write(1'b0, 8'h0D);
        bus_write(1'b1, 8'h01);
        check("t3_intrq_clear2", 8'(intrq), 8'h00);
        check("no_spurious_gap", 8'(gap_seen), 8'h00);

        // T4 short cs-high gap
        snap = gap_seen;
        bus_write(1'b0, 8'h40, 2);
        bus_write(1'b1, 8'h77);
        check("t4_gap_err_once", 8'(gap_seen - snap), 8'h01);
        bus_write(1'b0, 8'h40);
        bus_read(1'b1, 8'h77, "t4_mem");

        // T5 rd/wr overlap, then reset mid-read with strobes held
        bus_write(1'b0, 8'h50);
        bus_write(1'b1, 8'h3C);
        bus_write(1'b0, 8'h50);
        snap = oe_seen;
        check("t5_proto_idle", 8'(proto_seen), 8'h00);
        cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; data_in = 8'hEE;
        repeat (6) @(negedge clk);
        cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_proto_seen", 8'(proto_seen > 0), 8'h01);
        check("t5_proto_no_oe", 8'(oe_seen - snap), 8'h00);
        bus_read(1'b0, 8'h50, "t5_ptr_kept");
        bus_read(1'b1, 8'h3C, "t5_mem_kept");

        cs_n = 1'b0; rd_n = 1'b0; a0 = 1'b0; lat = 0;
        while (data_oe !== 1'b1 && lat < 12) begin @(negedge clk); lat++; end
        check("t5_oe_before_rst", 8'(data_oe), 8'h01);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("t5_oe_async_drop", 8'(data_oe), 8'h00);
        @(negedge clk);
        snap = oe_seen;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_held_strobe_ignored", 8'(oe_seen - snap), 8'h00);
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(1'b0, 8'h00, "t5_ptr_reset");

        // T6 local write collision vs. separate address
        snap = drop_seen;
        bus_write(1'b0, 8'h30);
        bus_write(1'b1, 8'h5A, 10, 1'b1, 8'h30, 8'hC3);
        check("t6_loc_drop", 8'(drop_seen - snap), 8'h01);
        bus_write(1'b0, 8'h30);
        bus_read(1'b1, 8'h5A, "t6_bus_wins");
        snap = drop_seen;
        bus_write(1'b0, 8'h30);
        bus_write(1'b1, 8'h66, 10, 1'b1, 8'h31, 8'h99);
        check("t6_no_drop", 8'(drop_seen - snap), 8'h00);
        bus_write(1'b0, 8'h30);
        bus_read(1'b1, 8'h66, "t6_bus_30");
        bus_read(1'b1, 8'h99, "t6_loc_31");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
